// File: rtl/time_param_pkg.sv
// Shared timer state type, interval index names and factory default
// interval values for the parametrised interval timer.
package time_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EXPIRED
    } timer_state_e;

    localparam int unsigned T_ARM_DELAY       = 0;
    localparam int unsigned T_DRIVER_DELAY    = 1;
    localparam int unsigned T_PASSENGER_DELAY = 2;
    localparam int unsigned T_ALARM_ON        = 3;

    localparam logic [3:0] DEF_ARM_DELAY       = 4'd6;
    localparam logic [3:0] DEF_DRIVER_DELAY    = 4'd8;
    localparam logic [3:0] DEF_PASSENGER_DELAY = 4'd15;
    localparam logic [3:0] DEF_ALARM_ON        = 4'd10;

endpackage

// File: rtl/param_interval_timer_countdown.sv
// Countdown engine: loads an interval, decrements it on each tick and
// pulses expired for one cycle when it completes.
module interval_countdown
    import time_param_pkg::*;
#(
    parameter int unsigned VALUE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [VALUE_W-1:0] load_value,
    input  logic               stop,
    input  logic               tick,
    output logic [VALUE_W-1:0] remaining,
    output logic               running,
    output logic               expired
);

    timer_state_e       state;
    timer_state_e       state_next;
    logic [VALUE_W-1:0] remaining_next;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Priority in COUNT is stop > load > tick; IDLE and EXPIRED share the load path.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        case (state)
            ST_COUNT: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (load) begin
                    remaining_next = load_value;
                    state_next     = (load_value == '0) ? ST_EXPIRED : ST_COUNT;
                end else if (tick) begin
                    remaining_next = remaining - 1'b1;
                    if (remaining == VALUE_W'(1)) begin
                        state_next = ST_EXPIRED;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                if (load && !stop) begin
                    remaining_next = load_value;
                    state_next     = (load_value == '0) ? ST_EXPIRED : ST_COUNT;
                end
            end
        endcase
    end

    assign running = (state == ST_COUNT);
    assign expired = (state == ST_EXPIRED);

endmodule

// File: rtl/param_interval_timer.sv
// Reprogrammable interval store with an integrated countdown engine.
// Optional macro TIME_PARAM_WRITE_LOCK_EN blocks writes while counting.
module param_interval_timer
    import time_param_pkg::*;
#(
    parameter int unsigned                    NUM_PARAMS = 4,
    parameter int unsigned                    VALUE_W    = 4,
    parameter int unsigned                    SEL_W      = $clog2(NUM_PARAMS),
    parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULTS   =
        {DEF_ALARM_ON, DEF_PASSENGER_DELAY, DEF_DRIVER_DELAY, DEF_ARM_DELAY}
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SEL_W-1:0]   time_param_sel,
    input  logic [VALUE_W-1:0] time_value,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   interval,
    output logic [VALUE_W-1:0] value,
    input  logic               start,
    input  logic               stop,
    input  logic               tick_1hz,
    output logic [VALUE_W-1:0] remaining,
    output logic               running,
    output logic               expired,
    output logic               write_rejected
);

    logic [VALUE_W-1:0] entries [NUM_PARAMS];
    logic               write_hit;
    logic               read_hit;
    logic               write_ok;

    assign write_hit = (32'(time_param_sel) < NUM_PARAMS);
    assign read_hit  = (32'(interval) < NUM_PARAMS);

`ifdef TIME_PARAM_WRITE_LOCK_EN
    assign write_ok = reprogram && !running;

    always_ff @(posedge clock) begin
        if (!reset) begin
            write_rejected <= 1'b0;
        end else begin
            write_rejected <= reprogram && running;
        end
    end
`else
    assign write_ok       = reprogram;
    assign write_rejected = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                entries[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
            end
        end else if (write_ok && write_hit) begin
            entries[time_param_sel] <= time_value;
        end
    end

    // The load sees the pre-edge entry, so a same-cycle write never leaks into it.
    assign value = read_hit ? entries[interval] : '0;

    interval_countdown #(
        .VALUE_W(VALUE_W)
    ) u_countdown (
        .clock      (clock),
        .reset      (reset),
        .load       (start && read_hit),
        .load_value (value),
        .stop       (stop),
        .tick       (tick_1hz),
        .remaining  (remaining),
        .running    (running),
        .expired    (expired)
    );

endmodule

// File: tb/tb_param_interval_timer.sv
// Self-checking bench for param_interval_timer: a cycle-level reference model
// checked every cycle, plus hand-computed literal checks along the test plan.
module tb_param_interval_timer;

    localparam int NP = 4;
    localparam int VW = 4;
`ifdef TIME_PARAM_WRITE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    time_param_sel;
    logic [VW-1:0] time_value;
    logic          reprogram;
    logic [1:0]    interval;
    logic [VW-1:0] value;
    logic          start;
    logic          stop;
    logic          tick_1hz;
    logic [VW-1:0] remaining;
    logic          running;
    logic          expired;
    logic          write_rejected;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_ent [NP];
    int m_rem;
    bit m_run;
    bit m_exp;
    bit m_rej;

    param_interval_timer #(
        .NUM_PARAMS(4),
        .VALUE_W   (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .reprogram      (reprogram),
        .interval       (interval),
        .value          (value),
        .start          (start),
        .stop           (stop),
        .tick_1hz       (tick_1hz),
        .remaining      (remaining),
        .running        (running),
        .expired        (expired),
        .write_rejected (write_rejected)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance at each rising edge, then compare shortly after it.
    always @(posedge clock) begin
        bit ld_ok;
        bit locked;
        bit new_exp;
        int ld_val;
        if (!reset) begin
            m_ent[0] = 6; m_ent[1] = 8; m_ent[2] = 15; m_ent[3] = 10;
            m_rem = 0; m_run = 0; m_exp = 0; m_rej = 0;
        end else begin
            ld_ok   = start && (int'(interval) < NP);
            ld_val  = ld_ok ? m_ent[interval] : 0;
            locked  = LOCK && m_run;
            m_rej   = LOCK && reprogram && m_run;
            new_exp = 0;
            if (stop && m_run) begin
                m_run = 0;
            end else if (ld_ok && !stop) begin
                m_rem = ld_val;
                if (ld_val == 0) begin
                    m_run = 0; new_exp = 1;
                end else begin
                    m_run = 1;
                end
            end else if (m_run && tick_1hz) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_run = 0; new_exp = 1;
                end
            end
            m_exp = new_exp;
            if (reprogram && !locked && int'(time_param_sel) < NP)
                m_ent[time_param_sel] = int'(time_value);
        end
        #1;
        chk("remaining", int'(remaining), m_rem);
        chk("running", int'(running), int'(m_run));
        chk("expired", int'(expired), int'(m_exp));
        chk("write_rejected", int'(write_rejected), int'(m_rej));
        chk("value", int'(value), (int'(interval) < NP) ? m_ent[interval] : 0);
    end

    task automatic cyc(input bit rep, input int sel, input int tv,
                       input int intv, input bit st, input bit sp, input bit tk);
        reprogram      = rep;
        time_param_sel = 2'(sel);
        time_value     = VW'(tv);
        interval       = 2'(intv);
        start          = st;
        stop           = sp;
        tick_1hz       = tk;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, int'(interval), 0, 0, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        reprogram = 0; time_param_sel = '0; time_value = '0; interval = '0;
        start = 0; stop = 0; tick_1hz = 0;
        idle(2);
        reset = 1'b1;
        chk("lit_reset_remaining", int'(remaining), 0);
        chk("lit_reset_running", int'(running), 0);
        chk("lit_reset_expired", int'(expired), 0);

        // Default readback
        interval = 2'd0; #1 chk("lit_def0", int'(value), 6);
        interval = 2'd1; #1 chk("lit_def1", int'(value), 8);
        interval = 2'd2; #1 chk("lit_def2", int'(value), 15);
        interval = 2'd3; #1 chk("lit_def3", int'(value), 10);
        idle(1);

        // Write 3 to entry 1, count it down
        cyc(1, 1, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("lit_load3", int'(remaining), 3);
        chk("lit_run_after_load", int'(running), 1);
        cyc(0, 0, 0, 1, 0, 0, 1); chk("lit_rem2", int'(remaining), 2);
        idle(1);
        cyc(0, 0, 0, 1, 0, 0, 1); chk("lit_rem1", int'(remaining), 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        chk("lit_rem0", int'(remaining), 0);
        chk("lit_exp_pulse", int'(expired), 1);
        chk("lit_run_in_exp", int'(running), 0);
        idle(1);
        chk("lit_exp_cleared", int'(expired), 0);

        // Zero-value load expires without a tick
        cyc(1, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2, 1, 0, 0);
        chk("lit_zero_exp", int'(expired), 1);
        chk("lit_zero_run", int'(running), 0);
        idle(2);

        // Start 15, two ticks, stop
        cyc(1, 2, 15, 2, 0, 0, 0);
        cyc(0, 0, 0, 2, 1, 0, 0);
        cyc(0, 0, 0, 2, 0, 0, 1);
        cyc(0, 0, 0, 2, 0, 0, 1);
        cyc(0, 0, 0, 2, 0, 1, 0);
        chk("lit_stop_rem", int'(remaining), 13);
        chk("lit_stop_run", int'(running), 0);
        chk("lit_stop_noexp", int'(expired), 0);
        cyc(0, 0, 0, 2, 1, 1, 0);
        chk("lit_startstop_run", int'(running), 0);
        chk("lit_startstop_rem", int'(remaining), 13);
        idle(1);

        // Start with simultaneous tick and write to the loaded entry
        cyc(1, 0, 9, 0, 1, 0, 1);
        chk("lit_old_load", int'(remaining), 6);
        interval = 2'd0; #1 chk("lit_new_entry0", int'(value), 9);
        // Write during COUNT
        cyc(1, 3, 5, 3, 0, 0, 0);
        chk("lit_cnt_write_rem", int'(remaining), 6);
        chk("lit_cnt_write_val", int'(value), LOCK ? 10 : 5);
        chk("lit_cnt_write_rej", int'(write_rejected), LOCK ? 1 : 0);
        idle(1);
        chk("lit_rej_cleared", int'(write_rejected), 0);
        // Reload mid-count from entry 1 (=3), then finish and restart in EXPIRED
        cyc(0, 0, 0, 1, 1, 0, 1);
        chk("lit_reload", int'(remaining), 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 1);
        chk("lit_exp2", int'(expired), 1);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("lit_start_in_exp", int'(running), 1);
        chk("lit_start_in_exp_rem", int'(remaining), 3);

        // Reset mid-count discards the count
        cyc(0, 0, 0, 1, 0, 0, 1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("lit_rst_rem", int'(remaining), 0);
        chk("lit_rst_run", int'(running), 0);
        idle(1);
        chk("lit_rst_noexp", int'(expired), 0);
        chk("lit_rst_entry1", int'(value), 8);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
